tile_sequencer: RTL and testbench

Per-tile phase controller for the DeiT accelerator. It sits between the AXI-Lite register file, the shared MM2S input stream, `deit_core` and the TX output path. Each tile runs weight load, input load, compute and drain in order. It routes inbound beats to the weight or input buffer by beat count instead of by core state, applies input back-pressure, pulses the core start and generates the output TLAST.

---
 rtl/tile_sequencer_pkg.sv | 18 +
 rtl/tile_sequencer_beat_counter.sv | 36 +++
 rtl/tile_sequencer.sv | 165 ++++++++++++++++
 tb/tb_tile_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_sequencer_pkg.sv
// Shared definitions for the tile sequencer: phase encodings and small helpers.
package tile_sequencer_pkg;

  // 3-bit phase encoding, also decoded by the debug register block.
  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD_W = 3'd1,
    SEQ_LOAD_I = 3'd2,
    SEQ_RUN    = 3'd3,
    SEQ_DRAIN  = 3'd4
  } seq_state_e;

  // Each tile starts with a weight load unless the job has no weight beats.
  function automatic seq_state_e first_load_state(input logic w_zero);
    return w_zero ? SEQ_LOAD_I : SEQ_LOAD_W;
  endfunction

endpackage

// File: rtl/tile_sequencer_beat_counter.sv
// Beat counter with synchronous clear, increment and terminal-count compares.
module beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] cfg_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o,
  output logic             full_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority so the terminal beat rewinds the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  // last: the next accepted beat is the final one; full: all beats seen.
  assign last_o = (cnt_q == (cfg_i - CNT_W'(1)));
  assign full_o = (cnt_q == cfg_i);

endmodule

// File: rtl/tile_sequencer.sv
// Per-tile phase controller: weight load, input load, compute, drain.
module tile_sequencer
  import tile_sequencer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_cfg_w_beats,
  input  logic [CNT_W-1:0]  i_cfg_i_beats,
  input  logic [CNT_W-1:0]  i_cfg_o_beats,
  input  logic [TILE_W-1:0] i_cfg_num_tiles,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              o_wbuf_valid,
  output logic              o_ibuf_valid,
  output logic              o_core_start,
  input  logic              i_core_done,
  input  logic              i_out_beat,
  output logic              o_out_tlast,
  output logic [TILE_W-1:0] o_tile_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  seq_state_e        state_q;
  logic [TILE_W-1:0] tile_q;
  logic              start_q;
  logic              done_q;
  logic              err_q;

  logic [CNT_W-1:0]  wcfg_q;
  logic [CNT_W-1:0]  icfg_q;
  logic [CNT_W-1:0]  ocfg_q;
  logic [TILE_W-1:0] ntile_q;

  logic in_load_w, in_load_i, in_run, in_drain, out_phase;
  logic in_beat, w_beat, i_beat, cur_last, tlast_err;
  logic out_acc, out_over, out_stray;
  logic start_acc, drain_exit, last_tile;
  logic w_clr, i_clr, o_clr;
  logic w_last, w_full, i_last, i_full, o_last, o_full;
  logic [CNT_W-1:0] w_cnt, i_cnt, o_cnt;
  logic unused_cnt;

  assign in_load_w = (state_q == SEQ_LOAD_W);
  assign in_load_i = (state_q == SEQ_LOAD_I);
  assign in_run    = (state_q == SEQ_RUN);
  assign in_drain  = (state_q == SEQ_DRAIN);
  assign out_phase = in_run | in_drain;

  // Inbound routing is decided by phase and beat count, never by core state.
  assign s_axis_tready = in_load_w | in_load_i;
  assign o_wbuf_valid  = in_load_w & s_axis_tvalid;
  assign o_ibuf_valid  = in_load_i & s_axis_tvalid;

  assign in_beat   = s_axis_tvalid & s_axis_tready;
  assign w_beat    = in_beat & in_load_w;
  assign i_beat    = in_beat & in_load_i;
  assign cur_last  = in_load_w ? w_last : i_last;
  assign tlast_err = in_beat & (s_axis_tlast != cur_last);

  // Output beats overlap compute, so RUN and DRAIN both count; excess is an error.
  assign out_acc   = i_out_beat & out_phase & ~o_full;
  assign out_over  = i_out_beat & out_phase & o_full;
  assign out_stray = i_out_beat & ~out_phase;

  assign start_acc  = i_start & (state_q == SEQ_IDLE);
  assign drain_exit = in_drain & (o_full | (out_acc & o_last));
  assign last_tile  = (tile_q == (ntile_q - TILE_W'(1)));

  assign w_clr = start_acc | (w_beat & w_last);
  assign i_clr = start_acc | (i_beat & i_last);
  assign o_clr = start_acc | drain_exit;

  beat_counter #(.CNT_W(CNT_W)) u_wcnt (
    .clk(clk), .rst_n(rst_n), .clr_i(w_clr), .inc_i(w_beat), .cfg_i(wcfg_q),
    .cnt_o(w_cnt), .last_o(w_last), .full_o(w_full)
  );

  beat_counter #(.CNT_W(CNT_W)) u_icnt (
    .clk(clk), .rst_n(rst_n), .clr_i(i_clr), .inc_i(i_beat), .cfg_i(icfg_q),
    .cnt_o(i_cnt), .last_o(i_last), .full_o(i_full)
  );

  beat_counter #(.CNT_W(CNT_W)) u_ocnt (
    .clk(clk), .rst_n(rst_n), .clr_i(o_clr), .inc_i(out_acc), .cfg_i(ocfg_q),
    .cnt_o(o_cnt), .last_o(o_last), .full_o(o_full)
  );

  // Load counters never reach full and raw counts are debug-only here.
  assign unused_cnt = ^{w_full, i_full, w_cnt, i_cnt, o_cnt};

  // Job configuration snapshot; a running job ignores later input changes.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      wcfg_q  <= i_cfg_w_beats;
      icfg_q  <= (i_cfg_i_beats == '0) ? CNT_W'(1) : i_cfg_i_beats;
      ocfg_q  <= i_cfg_o_beats;
      ntile_q <= i_cfg_num_tiles;
    end
  end

  // Phase FSM with registered start/done/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      tile_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (tlast_err | out_over | out_stray) err_q <= 1'b1;
      case (state_q)
        SEQ_IDLE: begin
          if (i_start) begin
            err_q  <= 1'b0;
            tile_q <= '0;
            if (i_cfg_num_tiles == '0) done_q  <= 1'b1;
            else                       state_q <= first_load_state(i_cfg_w_beats == '0);
          end
        end
        SEQ_LOAD_W: begin
          if (w_beat & w_last) state_q <= SEQ_LOAD_I;
        end
        SEQ_LOAD_I: begin
          if (i_beat & i_last) begin
            state_q <= SEQ_RUN;
            start_q <= 1'b1;
          end
        end
        SEQ_RUN: begin
          // The core's done is not trusted during its own start cycle.
          if (i_core_done & ~start_q) state_q <= SEQ_DRAIN;
        end
        SEQ_DRAIN: begin
          if (drain_exit) begin
            if (last_tile) begin
              state_q <= SEQ_IDLE;
              done_q  <= 1'b1;
            end else begin
              tile_q  <= tile_q + TILE_W'(1);
              state_q <= first_load_state(wcfg_q == '0);
            end
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign o_core_start = start_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_tile_idx   = tile_q;
  assign o_busy       = (state_q != SEQ_IDLE);
  assign o_out_tlast  = out_phase & o_last;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer with hand-computed expectations.
module tb_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] cw = '0, ci = '0, co = '0;
  logic [7:0]  ct = '0;
  logic        tvalid = 1'b0, tlast = 1'b0;
  logic        core_done = 1'b0, out_beat = 1'b0;
  logic        tready, wbuf_v, ibuf_v, core_start, out_tlast, busy, done, err;
  logic [7:0]  tile_idx;

  int checks = 0;
  int failures = 0;

  tile_sequencer #(.CNT_W(16), .TILE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_cfg_w_beats(cw), .i_cfg_i_beats(ci), .i_cfg_o_beats(co), .i_cfg_num_tiles(ct),
    .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .o_wbuf_valid(wbuf_v), .o_ibuf_valid(ibuf_v), .o_core_start(core_start),
    .i_core_done(core_done), .i_out_beat(out_beat), .o_out_tlast(out_tlast),
    .o_tile_idx(tile_idx), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then scramble the config inputs to prove they were latched.
  task automatic start_job(input int w, input int i, input int o, input int t);
    cw = 16'(w); ci = 16'(i); co = 16'(o); ct = 8'(t);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    cw = 16'd0; ci = 16'd2; co = 16'd7; ct = 8'd0;
  endtask

  // From the core-start cycle: wait one cycle, pulse done, let a zero-beat drain exit.
  task automatic finish_tile();
    tvalid = 1'b0; tlast = 1'b0;
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
  endtask

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", core_start, 0);
    chk("rst_tile", tile_idx, 0);

    // Full tile: w=4, i=8, o=2, one tile.
    start_job(4, 8, 2, 1);
    chk("t1_tready", tready, 1);
    chk("t1_busy", busy, 1);
    tvalid = 1'b1;
    for (int b = 1; b <= 12; b++) begin
      tlast = (b == 4 || b == 12);
      #1;
      chk("t1_wbuf", wbuf_v, (b <= 4));
      chk("t1_ibuf", ibuf_v, (b > 4));
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("t1_core_start", core_start, 1);
    chk("t1_tready_run", tready, 0);
    tick();
    chk("t1_start_once", core_start, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    out_beat = 1'b1;
    #1;
    chk("t1_tlast_b1", out_tlast, 0);
    chk("t1_nodone", done, 0);
    tick();
    chk("t1_tlast_b2", out_tlast, 1);
    tick();
    out_beat = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // Zero tiles: finish at once.
    start_job(1, 1, 1, 0);
    chk("t0_done", done, 1);
    chk("t0_busy", busy, 0);
    tick();

    // w=0, i=3, two tiles.
    start_job(0, 3, 0, 2);
    for (int t = 0; t < 2; t++) begin
      chk("t2_tile", tile_idx, t);
      tvalid = 1'b1;
      for (int b = 1; b <= 3; b++) begin
        tlast = (b == 3);
        #1;
        chk("t2_wbuf", wbuf_v, 0);
        chk("t2_ibuf", ibuf_v, 1);
        tick();
      end
      chk("t2_core_start", core_start, 1);
      finish_tile();
      if (t == 0) begin
        chk("t2_mid_done", done, 0);
        chk("t2_next_tile", tile_idx, 1);
        chk("t2_next_tready", tready, 1);
      end else begin
        chk("t2_done", done, 1);
        chk("t2_idle", busy, 0);
      end
    end
    tick();

    // Toggling tvalid during LOAD_I with i=5; done ignored on the start cycle.
    start_job(0, 5, 0, 1);
    for (int c = 0; c <= 8; c++) begin
      tvalid = (c % 2 == 0);
      tlast = (c == 8);
      #1;
      chk("t3_tready", tready, 1);
      chk("t3_ibuf", ibuf_v, tvalid);
      tick();
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("t3_core_start", core_start, 1);
    chk("t3_tready_run", tready, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("t3_early_done_ignored", busy, 1);
    chk("t3_nodone", done, 0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("t3_done", done, 1);
    chk("t3_err", err, 0);
    tick();

    // tlast on beat 2 of 4 sets err; phase still ends by count.
    start_job(4, 1, 0, 1);
    tvalid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      tlast = (b == 2);
      tick();
      if (b == 2) chk("t4_err_early", err, 1);
    end
    tlast = 1'b1;
    #1;
    chk("t4_ibuf", ibuf_v, 1);
    chk("t4_wbuf", wbuf_v, 0);
    tick();
    chk("t4_core_start", core_start, 1);
    chk("t4_err_sticky", err, 1);
    finish_tile();
    chk("t4_done", done, 1);
    start_job(0, 2, 0, 1);
    chk("t4_err_cleared", err, 0);
    tvalid = 1'b1; tlast = 1'b0;
    tick();
    tick();
    chk("t4_err_missing_tlast", err, 1);
    chk("t4b_core_start", core_start, 1);
    finish_tile();
    tick();

    // o=4: three beats during RUN, one in DRAIN, then a stray beat.
    start_job(0, 1, 4, 1);
    tvalid = 1'b1; tlast = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    chk("t5_core_start", core_start, 1);
    out_beat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_tlast_run", out_tlast, 0);
      tick();
    end
    out_beat = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    #1;
    chk("t5_drain_busy", busy, 1);
    chk("t5_nodone", done, 0);
    chk("t5_tlast_4th", out_tlast, 1);
    out_beat = 1'b1;
    tick();
    out_beat = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_err", err, 0);
    chk("t5_tlast_idle", out_tlast, 0);
    out_beat = 1'b1;
    tick();
    out_beat = 1'b0;
    chk("t5_err_extra", err, 1);
    tick();

    // Reset asserted in RUN.
    start_job(0, 1, 2, 2);
    tvalid = 1'b1; tlast = 1'b0;
    tick();
    tvalid = 1'b0;
    chk("t6_pre_err", err, 1);
    chk("t6_pre_start", core_start, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_start", core_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_tready", tready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start_job(0, 1, 0, 1);
    chk("t6_tile", tile_idx, 0);
    tvalid = 1'b1; tlast = 1'b1;
    tick();
    chk("t6_core_start", core_start, 1);
    finish_tile();
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
